// File: rtl/pong_vga_pkg.sv
// Shared VGA timing defaults, coordinate types and the sync-lock state encoding
// used by the Pong video output stage.
package pong_vga_pkg;

  localparam int VIDEO_WIDTH_DEF      = 4;
  localparam int TOTAL_COLS_DEF       = 800;
  localparam int TOTAL_ROWS_DEF       = 525;
  localparam int ACTIVE_COLS_DEF      = 640;
  localparam int ACTIVE_ROWS_DEF      = 480;
  localparam int FRONT_PORCH_HORZ_DEF = 18;
  localparam int BACK_PORCH_HORZ_DEF  = 50;
  localparam int FRONT_PORCH_VERT_DEF = 10;
  localparam int BACK_PORCH_VERT_DEF  = 33;

  typedef logic [$clog2(TOTAL_COLS_DEF)-1:0] col_t;
  typedef logic [$clog2(TOTAL_ROWS_DEF)-1:0] row_t;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } sync_state_e;

endpackage

// File: rtl/porch_sync_counter.sv
// Frame-start edge detect, lock tracking and col/row raster counters that
// reconstruct the upstream pixel position from the active-region VSync flag.
//
// state       | meaning
// ST_UNLOCKED | no frame start seen since reset; counters parked at 0,0
// ST_LOCKED   | counters follow the raster, resynchronised on every frame start
module porch_sync_counter
  import pong_vga_pkg::*;
#(
  parameter int TOTAL_COLS = TOTAL_COLS_DEF,
  parameter int TOTAL_ROWS = TOTAL_ROWS_DEF
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_L,
  input  logic                          i_VSync,
  output logic [$clog2(TOTAL_COLS)-1:0] col,
  output logic [$clog2(TOTAL_ROWS)-1:0] row,
  output logic                          locked,
  output logic                          frame_start
);

  localparam int CW = $clog2(TOTAL_COLS);
  localparam int RW = $clog2(TOTAL_ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(TOTAL_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(TOTAL_ROWS - 1);

  sync_state_e state, state_nxt;
  logic        prev_vsync;

  // prev_vsync resets high so a VSync already high at reset release is not an edge
  assign frame_start = i_VSync & ~prev_vsync;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) state <= ST_UNLOCKED;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_UNLOCKED: if (frame_start) state_nxt = ST_LOCKED;
      ST_LOCKED:   state_nxt = ST_LOCKED;
      default:     state_nxt = ST_UNLOCKED;
    endcase
  end

  always_comb begin
    locked = (state == ST_LOCKED);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      prev_vsync <= 1'b1;
      col        <= '0;
      row        <= '0;
    end else begin
      prev_vsync <= i_VSync;
      if (frame_start) begin
        col <= '0;
        row <= '0;
      end else if (locked) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_sync_porch.sv
// VGA output stage: regenerates porch-correct active-low syncs and blanks video.
// Define VGA_PORCH_SYNC_CHECK_EN to build the sticky frame-timing error check.
module vga_sync_porch
  import pong_vga_pkg::*;
#(
  parameter int VIDEO_WIDTH      = VIDEO_WIDTH_DEF,
  parameter int TOTAL_COLS       = TOTAL_COLS_DEF,
  parameter int TOTAL_ROWS       = TOTAL_ROWS_DEF,
  parameter int ACTIVE_COLS      = ACTIVE_COLS_DEF,
  parameter int ACTIVE_ROWS      = ACTIVE_ROWS_DEF,
  parameter int FRONT_PORCH_HORZ = FRONT_PORCH_HORZ_DEF,
  parameter int BACK_PORCH_HORZ  = BACK_PORCH_HORZ_DEF,
  parameter int FRONT_PORCH_VERT = FRONT_PORCH_VERT_DEF,
  parameter int BACK_PORCH_VERT  = BACK_PORCH_VERT_DEF
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
  output logic                   o_Sync_Err
);

  localparam int CW = $clog2(TOTAL_COLS);
  localparam int RW = $clog2(TOTAL_ROWS);
  localparam logic [CW-1:0] H_ACT     = CW'(ACTIVE_COLS);
  localparam logic [CW-1:0] H_SYNC_LO = CW'(ACTIVE_COLS + FRONT_PORCH_HORZ);
  localparam logic [CW-1:0] H_SYNC_HI = CW'(TOTAL_COLS - BACK_PORCH_HORZ - 1);
  localparam logic [RW-1:0] V_ACT     = RW'(ACTIVE_ROWS);
  localparam logic [RW-1:0] V_SYNC_LO = RW'(ACTIVE_ROWS + FRONT_PORCH_VERT);
  localparam logic [RW-1:0] V_SYNC_HI = RW'(TOTAL_ROWS - BACK_PORCH_VERT - 1);

  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic                   locked;
  logic                   frame_start;
  logic [VIDEO_WIDTH-1:0] red_q, grn_q, blu_q;
  logic                   col_active, row_active, h_pulse, v_pulse;

  porch_sync_counter #(
    .TOTAL_COLS (TOTAL_COLS),
    .TOTAL_ROWS (TOTAL_ROWS)
  ) u_counter (
    .i_Clk       (i_Clk),
    .i_Rst_L     (i_Rst_L),
    .i_VSync     (i_VSync),
    .col         (col),
    .row         (row),
    .locked      (locked),
    .frame_start (frame_start)
  );

  assign col_active = (col < H_ACT);
  assign row_active = (row < V_ACT);
  assign h_pulse    = (col >= H_SYNC_LO) && (col <= H_SYNC_HI);
  assign v_pulse    = (row >= V_SYNC_LO) && (row <= V_SYNC_HI);

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      red_q <= '0;
      grn_q <= '0;
      blu_q <= '0;
    end else begin
      red_q <= i_Red_Video;
      grn_q <= i_Grn_Video;
      blu_q <= i_Blu_Video;
    end
  end

  // counters sit at 0,0 while unlocked, so every decode is gated by locked
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      o_HSync     <= 1'b1;
      o_VSync     <= 1'b1;
      o_Red_Video <= '0;
      o_Grn_Video <= '0;
      o_Blu_Video <= '0;
    end else begin
      o_HSync <= ~(locked & h_pulse);
      o_VSync <= ~(locked & v_pulse);
      if (locked && col_active && row_active) begin
        o_Red_Video <= red_q;
        o_Grn_Video <= grn_q;
        o_Blu_Video <= blu_q;
      end else begin
        o_Red_Video <= '0;
        o_Grn_Video <= '0;
        o_Blu_Video <= '0;
      end
    end
  end

`ifdef VGA_PORCH_SYNC_CHECK_EN
  localparam logic [CW-1:0] COL_LAST = CW'(TOTAL_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(TOTAL_ROWS - 1);

  logic hsync_q;
  logic sync_err;
  logic early_start;
  logic hsync_bad;

  assign early_start = frame_start && locked && !((col == COL_LAST) && (row == ROW_LAST));
  assign hsync_bad   = locked && (hsync_q != col_active);

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      hsync_q  <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      hsync_q <= i_HSync;
      if (early_start || hsync_bad) sync_err <= 1'b1;
    end
  end

  assign o_Sync_Err = sync_err;
`else
  logic unused_chk;
  assign unused_chk = ^{i_HSync, frame_start};
  assign o_Sync_Err = 1'b0;
`endif

endmodule
